mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single-ported unified SimpleRisc memory, shared between the IF stage (instruction fetch) and the MA stage (load/store). It sits between the two pipeline stages and the memory model. It serialises their requests through a fixed-latency access sequence and returns data with a one-cycle valid pulse. MA has priority because it holds the older instruction, and an optional fairness counter bounds how long IF can be starved.

## Interface
- `MEM_LATENCY`, default 2: cycles from the `mem_en` cycle to valid `mem_rdata`. Must be ≥1.
- `MAX_MA_STREAK`, default 4: consecutive MA grants allowed while IF waits. Used only with fairness compiled in.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `if_req`  in  1  IF request; held with `if_addr` until `if_rvalid` or flush.
- `if_addr`  in  32  fetch address.
- `if_flush`  in  1  branch taken; cancels any in-flight IF access.
- `if_gnt`  out  1  one-cycle pulse: IF access issued.
- `if_rvalid`  out  1  one-cycle pulse: `if_rdata` valid.
- `if_rdata`  out  32  fetched instruction.
- `ma_req`, `ma_we`  in  1  MA request and write select.
- `ma_addr`, `ma_wdata`  in  32  MA address and store data.
- `ma_gnt`, `ma_rvalid`  out  1  issue pulse and completion pulse; completion also applies to stores.
- `ma_rdata`  out  32  load data; unchanged on store completion.
- `mem_en`, `mem_we`  out  1  memory strobe and write enable.
- `mem_addr`, `mem_wdata`  out  32  memory address and write data.
- `mem_rdata`  in  32  memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Encoding comes from the package.
- **IDLE:** arbitrate on sampled requests.
  - `ma_req` wins over `if_req`, except under fairness (see Configuration).
  - With no request, stay in IDLE.
  - On a winner, latch owner, address, we and wdata, then go to ISSUE.
- **ISSUE (one cycle):**
  - `mem_en`=1.
  - `mem_addr`, `mem_we`, `mem_wdata` driven from the latched values.
  - Owner's `gnt`=1.
  - Load the latency counter with `MEM_LATENCY`-1, then go to WAIT.
- **WAIT:**
  - Decrement the counter each cycle.
  - When the counter is 0, capture `mem_rdata` into the owner's rdata register (loads and fetches only), then go to RESP.
  - With `MEM_LATENCY`=1, WAIT lasts one cycle.
- **RESP (one cycle):**
  - Owner's `rvalid`=1, then go to IDLE.
  - No arbitration happens in RESP.
  - A requester may keep `req` high after RESP; that is treated as a new request.
- **Flush:**
  - `if_flush`=1 while the owner is IF (ISSUE, WAIT or RESP) sets a cancel flag.
  - The memory access still completes and the sequence still runs.
  - `if_rvalid` is suppressed and `if_rdata` is not updated.
  - `if_flush` in IDLE has no effect. IF deasserts `if_req` itself.
- **Simultaneous requests in IDLE:** exactly one grant. The loser keeps waiting with its request held.
- **Outputs:** `mem_*` outputs are 0 outside ISSUE. `mem_we` is never 1 when the owner is IF.

## Timing
- **Reset values:** all outputs 0, both rdata registers 0, FSM in IDLE, streak counter 0.
- **Reset mid-access:** the access is abandoned immediately, with no `rvalid` and `mem_en` dropped asynchronously.
- **Latency for request sampled in IDLE at cycle t:**
  - `gnt` and `mem_en` at t+1.
  - `mem_rdata` sampled at t+`MEM_LATENCY`+1.
  - `rvalid` at t+`MEM_LATENCY`+2.
- **Throughput:** one access per `MEM_LATENCY`+3 cycles, because IDLE is revisited between accesses.
- **Registered outputs:** all outputs come from registers, with no combinational path from inputs to outputs.
- **Held inputs:** `*_addr`, `ma_we` and `ma_wdata` are latched in IDLE. Changes after the grant are ignored.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - A streak counter, width $clog2(`MAX_MA_STREAK`+1), counts MA grants made while `if_req`=1.
  - In IDLE, if the counter equals `MAX_MA_STREAK` and `if_req`=1, IF wins even when `ma_req`=1.
  - The counter clears on any IF grant, and on any MA grant made with `if_req`=0.
- Undefined: strict MA priority. No counter is instantiated, and IF can starve indefinitely.

## Structure
- Package `mem_arb_pkg`:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - owner enum {OWN_IF, OWN_MA}.
  - `MEM_ADDR_W` = 32 and `MEM_DATA_W` = 32.
- One sub-module, `mem_arb_latency_ctr`: a loadable down-counter with a zero flag, also reused for the streak count under `MEM_ARB_FAIRNESS_EN`.
- FSM, latches and output registers live in the top module.

## Test plan
- **IF-only fetch:** `if_req`=1, `if_addr`=0x10, memory returns 0xE000_0001 with `MEM_LATENCY`=2, request at cycle 0.
  - `if_gnt` and `mem_en` at cycle 1.
  - `if_rvalid` at cycle 4 with `if_rdata`=0xE000_0001.
- **Simultaneous request:** `ma_req` (load from 0x40) and `if_req` both rise at cycle 0.
  - MA is granted at cycle 1 and its `rvalid` comes at cycle 4.
  - IF is granted at cycle 6.
- **Store:** `ma_we`=1, `ma_addr`=0x80, `ma_wdata`=0x1234.
  - One `mem_en` cycle with `mem_we`=1, `mem_addr`=0x80, `mem_wdata`=0x1234.
  - `ma_rvalid` pulses and `ma_rdata` is unchanged.
- **Flush:** `if_flush` pulsed during WAIT of an IF access.
  - `mem_en` still seen once.
  - No `if_rvalid`; `if_rdata` keeps its old value.
  - FSM returns to IDLE on schedule.
- **Fairness:** `ma_req` and `if_req` held high, `MAX_MA_STREAK`=4.
  - With `MEM_ARB_FAIRNESS_EN`: grants MA,MA,MA,MA,IF repeating.
  - Without it: only MA grants.
- **Reset mid-access:** `reset` pulled low during WAIT.
  - All outputs are 0 within the same cycle.
  - After release, a new `if_req` is served with normal latency.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the SimpleRisc unified-memory port arbiter.
package mem_arb_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_MA = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_latency_ctr.sv
// Loadable saturating down-counter with a zero flag; times the memory
// access and, with MEM_ARB_FAIRNESS_EN, tracks the remaining MA streak budget.
module mem_arb_latency_ctr #(
  parameter int               WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= RST_VAL;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// IF/MA arbiter and fixed-latency sequencer for the single-ported memory.
// Optional MA-streak fairness is compiled in with `define MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY   = 2,
  parameter int MAX_MA_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [MEM_ADDR_W-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [MEM_DATA_W-1:0] if_rdata,
  input  logic                  ma_req,
  input  logic                  ma_we,
  input  logic [MEM_ADDR_W-1:0] ma_addr,
  input  logic [MEM_DATA_W-1:0] ma_wdata,
  output logic                  ma_gnt,
  output logic                  ma_rvalid,
  output logic [MEM_DATA_W-1:0] ma_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic [MEM_DATA_W-1:0] mem_rdata
);

  localparam int               LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 1);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be at least 1");
  end
  if (MAX_MA_STREAK < 1) begin : g_bad_streak
    $error("mem_port_arbiter: MAX_MA_STREAK must be at least 1");
  end

  arb_state_e state_q, state_d;
  arb_owner_e owner_q, owner_d;
  logic       we_q, we_d;
  logic       cancel_q, cancel_d;
  logic       start_if, start_ma, force_if;
  logic       lat_load, lat_dec, lat_zero, capture, kill;

  logic                  if_gnt_d, ma_gnt_d, mem_en_d, mem_we_d;
  logic                  if_rvalid_d, ma_rvalid_d;
  logic [MEM_ADDR_W-1:0] mem_addr_d;
  logic [MEM_DATA_W-1:0] mem_wdata_d, if_rdata_d, ma_rdata_d;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int                  STREAK_W   = $clog2(MAX_MA_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MA_STREAK);

  // Counts down the MA grants IF may still sit through; zero means IF is owed a turn.
  logic streak_zero;

  mem_arb_latency_ctr #(
    .WIDTH   (STREAK_W),
    .RST_VAL (STREAK_MAX)
  ) u_streak_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (start_if || (start_ma && !if_req)),
    .load_val (STREAK_MAX),
    .dec      (start_ma && if_req),
    .zero     (streak_zero)
  );

  assign force_if = if_req && streak_zero;
`else
  assign force_if = 1'b0;
`endif

  assign start_ma = (state_q == IDLE) && ma_req && !force_if;
  assign start_if = (state_q == IDLE) && if_req && !start_ma;

  mem_arb_latency_ctr #(
    .WIDTH   (LAT_W),
    .RST_VAL ({LAT_W{1'b0}})
  ) u_lat_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (lat_load),
    .load_val (LAT_INIT),
    .dec      (lat_dec),
    .zero     (lat_zero)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    cancel_d = cancel_q;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    capture  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_ma || start_if) begin
          state_d  = ISSUE;
          owner_d  = start_ma ? OWN_MA : OWN_IF;
          we_d     = start_ma && ma_we;
          cancel_d = 1'b0;
        end
      end
      ISSUE: begin
        lat_load = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (lat_zero) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          lat_dec = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && (owner_q == OWN_IF) && if_flush) begin
      cancel_d = 1'b1;
    end

    // A flush arriving on the capture cycle itself must still suppress the result.
    kill = cancel_q || if_flush;

    if_gnt_d    = start_if;
    ma_gnt_d    = start_ma;
    mem_en_d    = start_if || start_ma;
    mem_we_d    = start_ma && ma_we;
    mem_addr_d  = start_ma ? ma_addr : (start_if ? if_addr : '0);
    mem_wdata_d = start_ma ? ma_wdata : '0;
    if_rvalid_d = capture && (owner_q == OWN_IF) && !kill;
    ma_rvalid_d = capture && (owner_q == OWN_MA);
    if_rdata_d  = if_rvalid_d ? mem_rdata : if_rdata;
    ma_rdata_d  = (ma_rvalid_d && !we_q) ? mem_rdata : ma_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      we_q      <= 1'b0;
      cancel_q  <= 1'b0;
      if_gnt    <= 1'b0;
      ma_gnt    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      ma_rvalid <= 1'b0;
      if_rdata  <= '0;
      ma_rdata  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      cancel_q  <= cancel_d;
      if_gnt    <= if_gnt_d;
      ma_gnt    <= ma_gnt_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rvalid <= if_rvalid_d;
      ma_rvalid <= ma_rvalid_d;
      if_rdata  <= if_rdata_d;
      ma_rdata  <= ma_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a transaction-level timing model and
// two shadow memories predict every output cycle by cycle.
module tb_mem_port_arbiter;

  localparam int L    = 2;
  localparam int MAXS = 4;
`ifdef MEM_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, ma_req, ma_we;
  logic [31:0] if_addr, ma_addr, ma_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, ma_gnt, ma_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, ma_rdata, mem_addr, mem_wdata;

  mem_port_arbiter #(
    .MEM_LATENCY   (L),
    .MAX_MA_STREAK (MAXS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ma_req    (ma_req),
    .ma_we     (ma_we),
    .ma_addr   (ma_addr),
    .ma_wdata  (ma_wdata),
    .ma_gnt    (ma_gnt),
    .ma_rvalid (ma_rvalid),
    .ma_rdata  (ma_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%08h, expected 0x%08h", tag, cyc, got, exp);
    end
  endtask

  // Memory contents: model copy written at grant, responder copy written by the DUT.
  logic [31:0] ref_mem  [int unsigned];
  logic [31:0] resp_mem [int unsigned];

  function automatic logic [31:0] seed_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return seed_word(a);
  endfunction

  function automatic logic [31:0] resp_rd(input logic [31:0] a);
    if (resp_mem.exists(a)) return resp_mem[a];
    return seed_word(a);
  endfunction

  // Access model: an access granted from inputs of cycle t0 shows gnt/mem_en
  // at t0+1, rvalid at t0+L+2, and the port is free again at t0+L+3.
  bit          t0_ok, own_ma, m_we, cancel;
  int          t0, streak, if_end, ma_end, resp_due;
  logic [31:0] m_addr, m_wdata, m_rdata, exp_if_rdata, exp_ma_rdata, resp_addr;
  bit          did_reset, rst_hold;

  task automatic check_zero(input string tag);
    check_eq({tag, " if_gnt"},    if_gnt,    0);
    check_eq({tag, " ma_gnt"},    ma_gnt,    0);
    check_eq({tag, " if_rvalid"}, if_rvalid, 0);
    check_eq({tag, " ma_rvalid"}, ma_rvalid, 0);
    check_eq({tag, " mem_en"},    mem_en,    0);
    check_eq({tag, " mem_we"},    mem_we,    0);
    check_eq({tag, " mem_addr"},  mem_addr,  0);
    check_eq({tag, " mem_wdata"}, mem_wdata, 0);
    check_eq({tag, " if_rdata"},  if_rdata,  0);
    check_eq({tag, " ma_rdata"},  ma_rdata,  0);
  endtask

  task automatic check_all(input int n);
    int d;
    bit iss, rsp;
    d   = t0_ok ? (n - t0) : -1;
    iss = (d == 1);
    rsp = (d == L + 2);
    if (rsp && !own_ma && !cancel) exp_if_rdata = m_rdata;
    if (rsp && own_ma && !m_we)    exp_ma_rdata = m_rdata;
    check_eq("if_gnt",    if_gnt,    32'(iss && !own_ma));
    check_eq("ma_gnt",    ma_gnt,    32'(iss && own_ma));
    check_eq("mem_en",    mem_en,    32'(iss));
    check_eq("mem_we",    mem_we,    32'(iss && own_ma && m_we));
    check_eq("mem_addr",  mem_addr,  iss ? m_addr : 32'h0);
    if (iss && own_ma)  check_eq("mem_wdata", mem_wdata, m_wdata);
    else if (!iss)      check_eq("mem_wdata", mem_wdata, 32'h0);
    check_eq("if_rvalid", if_rvalid, 32'(rsp && !own_ma && !cancel));
    check_eq("ma_rvalid", ma_rvalid, 32'(rsp && own_ma));
    check_eq("if_rdata",  if_rdata,  exp_if_rdata);
    check_eq("ma_rdata",  ma_rdata,  exp_ma_rdata);
  endtask

  task automatic respond(input int n);
    if (mem_en && mem_we) begin
      resp_mem[mem_addr] = mem_wdata;
    end else if (mem_en) begin
      resp_due  = n + L;
      resp_addr = mem_addr;
    end
    mem_rdata = (resp_due == n) ? resp_rd(resp_addr) : $urandom;
  endtask

  task automatic drive(input int n, input bit busy_mode);
    int d;
    bit free;
    d    = t0_ok ? (n - t0) : -1;
    free = !t0_ok || (d >= L + 3);
    if_flush = 1'b0;
    if (if_req && if_end == n) begin if_req = 1'b0; if_end = -1; end
    if (ma_req && ma_end == n) begin ma_req = 1'b0; ma_end = -1; end
    if (t0_ok && !own_ma && d >= 1 && d <= L + 1 && $urandom_range(0, 5) == 0) begin
      if_flush = 1'b1;
      if (if_end != -1) begin if_req = 1'b0; if_end = -1; end
    end else if (free && $urandom_range(0, 7) == 0) begin
      if_flush = 1'b1;
    end
    if (!if_req && (busy_mode || $urandom_range(0, 3) == 0)) begin
      if_req  = 1'b1;
      if_addr = 32'($urandom_range(0, 15)) << 2;
    end
    if (!ma_req && (busy_mode || $urandom_range(0, 3) == 0)) begin
      ma_req   = 1'b1;
      ma_we    = 1'($urandom_range(0, 1));
      ma_addr  = 32'($urandom_range(0, 15)) << 2;
      ma_wdata = $urandom;
    end
    // Once granted, the request fields must no longer matter.
    if (if_req && if_end != -1) if_addr = $urandom;
    if (ma_req && ma_end != -1) begin
      ma_addr  = $urandom;
      ma_wdata = $urandom;
      ma_we    = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic model_step(input int n);
    int d;
    bit free, fair_if;
    d = t0_ok ? (n - t0) : -1;
    if (t0_ok && !own_ma && if_flush && d >= 1 && d <= L + 1) cancel = 1'b1;
    free = !t0_ok || (d >= L + 3);
    if (free) begin
      fair_if = FAIR && if_req && (streak == MAXS);
      if (ma_req && !fair_if) begin
        own_ma  = 1'b1;
        m_we    = ma_we;
        m_addr  = ma_addr;
        m_wdata = ma_wdata;
        m_rdata = ma_we ? 32'h0 : ref_rd(ma_addr);
        if (ma_we) ref_mem[ma_addr] = ma_wdata;
        streak  = if_req ? streak + 1 : 0;
        ma_end  = n + L + 2;
        t0 = n; t0_ok = 1'b1; cancel = 1'b0;
      end else if (if_req) begin
        own_ma  = 1'b0;
        m_we    = 1'b0;
        m_addr  = if_addr;
        m_wdata = 32'h0;
        m_rdata = ref_rd(if_addr);
        streak  = 0;
        if_end  = n + L + 2;
        t0 = n; t0_ok = 1'b1; cancel = 1'b0;
      end
    end
  endtask

  task automatic clear_state();
    if_req = 1'b0; if_flush = 1'b0; ma_req = 1'b0; ma_we = 1'b0;
    if_addr = 32'h0; ma_addr = 32'h0; ma_wdata = 32'h0; mem_rdata = 32'h0;
    t0_ok = 1'b0; t0 = 0; own_ma = 1'b0; m_we = 1'b0; cancel = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; m_rdata = 32'h0;
    exp_if_rdata = 32'h0; exp_ma_rdata = 32'h0;
    streak = 0; if_end = -1; ma_end = -1; resp_due = -1; resp_addr = 32'h0;
  endtask

  initial begin
    reset = 1'b0;
    clear_state();
    did_reset = 1'b0;
    rst_hold  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int it = 0; it < 2400; it++) begin
      @(negedge clk);
      cyc++;
      if (rst_hold) begin
        reset    = 1'b1;
        rst_hold = 1'b0;
      end
      check_all(cyc);
      if (!did_reset && cyc > 300 && t0_ok && !own_ma && (cyc - t0) == 2) begin
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        clear_state();
        did_reset = 1'b1;
        rst_hold  = 1'b1;
        continue;
      end
      respond(cyc);
      drive(cyc, it >= 1800);
      model_step(cyc);
    end

    check_eq("mid_reset_hit", 32'(did_reset), 32'h1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
